pll_rst_seq: RTL and testbench
==============================

# pll_rst_seq

Power-on clock/reset sequencer for the two-PLL clock unit (RTC PLL, system PLL). It runs on the free-running board input clock, so it works before either PLL is up. It drives the PLL reset inputs in order and qualifies each lock with a stability window, retrying with a timeout on failure. After both PLLs are locked it releases peripheral reset, then core reset. Any lock loss or software restart request drops the core back into reset and restarts the sequence.

## Interface
- RST_CYC, 16: cycles both PLL resets are held asserted per attempt (≥1)
- STABLE_CYC, 64: consecutive synced-lock-high cycles required to qualify a lock (≥1)
- TMO_CYC, 65536: maximum cycles in a WAIT state before the attempt fails (> STABLE_CYC)
- GAP_CYC, 8: cycles between periph_rst_n release and core_rst_n release (≥1)
- MAX_RETRY, 3: failed attempts allowed before FAULT
- Counter width = clog2(TMO_CYC+1); retry counter width = clog2(MAX_RETRY+1)

Ports:
- clk  in  1  free-running board input clock (PLL reference)
- rst_n  in  1  reset, asynchronous, active-low
- pll_lock_rtc  in  1  RTC PLL lock, asynchronous to clk
- pll_lock_sys  in  1  system PLL lock, asynchronous to clk
- restart_req  in  1  single-cycle pulse in clk domain; honored only in RUN
- pll_rtc_rst  out  1  RTC PLL reset, active-high
- pll_sys_rst  out  1  system PLL reset, active-high
- periph_rst_n  out  1  peripheral reset, active-low
- core_rst_n  out  1  core reset, active-low
- running  out  1  high when state == RUN
- fault  out  1  sticky failure flag
- seq_state  out  3  0 RST_PLL, 1 WAIT_RTC, 2 WAIT_SYS, 3 GAP, 4 RUN, 5 FAULT
- lock_loss_cnt  out  8  lock-loss events seen while in GAP or RUN; saturates at 255

## Operation
- Both lock inputs pass through 2-flop synchronizers (lock_rtc_s, lock_sys_s). All FSM decisions use the synced values. All outputs are registered.
- Reset values: state RST_PLL, pll_rtc_rst=1, pll_sys_rst=1, periph_rst_n=0, core_rst_n=0, running=0, fault=0, lock_loss_cnt=0, retry_cnt=0, counters=0, synchronizer flops=0.
- RST_PLL: both PLL resets asserted. After RST_CYC cycles in this state, pll_rtc_rst falls and the FSM enters WAIT_RTC.
- WAIT_RTC: stable counter increments while lock_rtc_s=1 and clears when it is 0. After STABLE_CYC consecutive high cycles, pll_sys_rst falls and the FSM enters WAIT_SYS.
- WAIT_SYS: same qualification on lock_sys_s. If lock_rtc_s=0 in this state, the attempt fails immediately. On qualification, periph_rst_n rises and the FSM enters GAP.
- GAP: after GAP_CYC cycles, core_rst_n rises and the FSM enters RUN.
- Timeout: the state counter clears on entry to each WAIT state. Reaching TMO_CYC cycles without qualification fails the attempt. If qualification and timeout occur in the same cycle, qualification wins.
- Failed attempt:
  - retry_cnt < MAX_RETRY: retry_cnt increments; on the same edge both PLL resets assert; the FSM enters RST_PLL.
  - Otherwise: enter FAULT. fault=1, both PLL resets asserted, periph/core held in reset. FAULT exits only on rst_n.
- Lock loss in GAP or RUN (either lock_*_s = 0):
  - On the same edge: core_rst_n=0, periph_rst_n=0, both PLL resets=1, state RST_PLL.
  - lock_loss_cnt increments (saturating); retry_cnt clears.
- restart_req in RUN: same as lock loss, except lock_loss_cnt is unchanged. restart_req is ignored in every other state.
- Reset release order is guaranteed: core_rst_n never rises while periph_rst_n=0. Both fall together.
- rst_n asserted at any time returns every output to its reset value asynchronously.

## Timing
- Cycle 1 is the first clk rising edge after rst_n deasserts.
- pll_rtc_rst falls at the end of cycle RST_CYC.
- Raw lock to visible in lock_*_s: 2 cycles. Synced lock rising to the qualifying transition: STABLE_CYC cycles.
- Best-case rst_n release to core_rst_n=1: RST_CYC + 2×(2+STABLE_CYC) + GAP_CYC cycles, assuming each PLL locks instantly.
- Lock loss to core_rst_n=0: 3 cycles (2 synchronizer + 1 registered).

## Test plan
Bench parameters: RST_CYC=4, STABLE_CYC=8, TMO_CYC=64, GAP_CYC=4, MAX_RETRY=2.

- **Nominal.** Both locks tied high before reset release → pll_rtc_rst falls after cycle 4; pll_sys_rst falls after cycle 14; periph_rst_n rises after cycle 24; core_rst_n and running rise after cycle 28.
- **Glitchy lock.** lock_rtc pulses high 5 cycles, low 1 cycle, then steady high → stable counter restarts; WAIT_SYS is entered 8 cycles after the steady synced high.
- **Timeout and fault.** lock_sys never asserts → three WAIT_SYS timeouts with retry_cnt 0→1→2; then seq_state=5, fault=1, core_rst_n=0. Only rst_n clears it.
- **Lock loss in RUN.** In RUN, drop lock_sys for 1 cycle → core_rst_n=0 3 cycles later; lock_loss_cnt=1; the full sequence re-runs.
- **Restart request.** restart_req pulse in RUN → restart without changing lock_loss_cnt. The same pulse during WAIT_RTC is ignored.
- **Mid-sequence reset.** rst_n asserted in GAP → all outputs return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/pll_rst_seq.sv
// Power-on clock/reset sequencer for the RTC and system PLLs.
// Brings up each PLL in turn, qualifies its lock, then releases peripheral and core reset.
module pll_rst_seq #(
    parameter int RST_CYC    = 16,
    parameter int STABLE_CYC = 64,
    parameter int TMO_CYC    = 65536,
    parameter int GAP_CYC    = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_rtc,
    input  logic       pll_lock_sys,
    input  logic       restart_req,
    output logic       pll_rtc_rst,
    output logic       pll_sys_rst,
    output logic       periph_rst_n,
    output logic       core_rst_n,
    output logic       running,
    output logic       fault,
    output logic [2:0] seq_state,
    output logic [7:0] lock_loss_cnt
);

    // state     | meaning
    // RST_PLL   | both PLL resets held for RST_CYC cycles
    // WAIT_RTC  | RTC PLL out of reset, qualifying its lock
    // WAIT_SYS  | system PLL out of reset, qualifying its lock
    // GAP       | peripherals released, core still in reset
    // RUN       | everything out of reset
    // FAULT     | retries exhausted, held until rst_n
    typedef enum logic [2:0] {
        ST_RST_PLL  = 3'd0,
        ST_WAIT_RTC = 3'd1,
        ST_WAIT_SYS = 3'd2,
        ST_GAP      = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam int CW = $clog2(TMO_CYC + 1);
    localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYC - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          rtc_meta_q, rtc_meta_d, lock_rtc_s_q, lock_rtc_s_d;
    logic          sys_meta_q, sys_meta_d, lock_sys_s_q, lock_sys_s_d;
    logic          pll_rtc_rst_q, pll_rtc_rst_d, pll_sys_rst_q, pll_sys_rst_d;
    logic          periph_rst_n_q, periph_rst_n_d, core_rst_n_q, core_rst_n_d;
    logic          running_q, running_d, fault_q, fault_d;
    logic          fail, lock_loss, restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RST_PLL;
            cnt_q          <= '0;
            stab_q         <= '0;
            retry_q        <= '0;
            loss_q         <= '0;
            rtc_meta_q     <= 1'b0;
            lock_rtc_s_q   <= 1'b0;
            sys_meta_q     <= 1'b0;
            lock_sys_s_q   <= 1'b0;
            pll_rtc_rst_q  <= 1'b1;
            pll_sys_rst_q  <= 1'b1;
            periph_rst_n_q <= 1'b0;
            core_rst_n_q   <= 1'b0;
            running_q      <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stab_q         <= stab_d;
            retry_q        <= retry_d;
            loss_q         <= loss_d;
            rtc_meta_q     <= rtc_meta_d;
            lock_rtc_s_q   <= lock_rtc_s_d;
            sys_meta_q     <= sys_meta_d;
            lock_sys_s_q   <= lock_sys_s_d;
            pll_rtc_rst_q  <= pll_rtc_rst_d;
            pll_sys_rst_q  <= pll_sys_rst_d;
            periph_rst_n_q <= periph_rst_n_d;
            core_rst_n_q   <= core_rst_n_d;
            running_q      <= running_d;
            fault_q        <= fault_d;
        end
    end

    always_comb begin
        // A PLL held in reset cannot report a valid lock, so its synchronizer is flushed.
        rtc_meta_d   = pll_rtc_rst_q ? 1'b0 : pll_lock_rtc;
        lock_rtc_s_d = pll_rtc_rst_q ? 1'b0 : rtc_meta_q;
        sys_meta_d   = pll_sys_rst_q ? 1'b0 : pll_lock_sys;
        lock_sys_s_d = pll_sys_rst_q ? 1'b0 : sys_meta_q;

        state_d   = state_q;
        cnt_d     = '0;
        stab_d    = '0;
        retry_d   = retry_q;
        loss_d    = loss_q;
        fail      = 1'b0;
        lock_loss = 1'b0;
        restart   = 1'b0;

        case (state_q)
            ST_RST_PLL: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_RTC;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_WAIT_RTC: begin
                if (lock_rtc_s_q && (stab_q == STABLE_LAST)) begin
                    state_d = ST_WAIT_SYS;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    stab_d = lock_rtc_s_q ? stab_q + 1'b1 : '0;
                end
            end
            ST_WAIT_SYS: begin
                if (!lock_rtc_s_q) begin
                    fail = 1'b1;
                end else if (lock_sys_s_q && (stab_q == STABLE_LAST)) begin
                    state_d = ST_GAP;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    stab_d = lock_sys_s_q ? stab_q + 1'b1 : '0;
                end
            end
            ST_GAP: begin
                if (!lock_rtc_s_q || !lock_sys_s_q) lock_loss = 1'b1;
                else if (cnt_q == GAP_LAST)         state_d   = ST_RUN;
                else                                cnt_d     = cnt_q + 1'b1;
            end
            ST_RUN: begin
                if (!lock_rtc_s_q || !lock_sys_s_q) lock_loss = 1'b1;
                else if (restart_req)               restart   = 1'b1;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_RST_PLL;
        endcase

        if (fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_RST_PLL;
            end else begin
                state_d = ST_FAULT;
            end
        end

        if (lock_loss || restart) begin
            state_d = ST_RST_PLL;
            retry_d = '0;
            if (lock_loss && (loss_q != 8'hFF)) loss_d = loss_q + 1'b1;
        end

        // Outputs follow the next state so every output is a flop that changes with the transition.
        pll_rtc_rst_d  = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
        pll_sys_rst_d  = (state_d == ST_RST_PLL) || (state_d == ST_WAIT_RTC) || (state_d == ST_FAULT);
        periph_rst_n_d = (state_d == ST_GAP) || (state_d == ST_RUN);
        core_rst_n_d   = (state_d == ST_RUN);
        running_d      = (state_d == ST_RUN);
        fault_d        = fault_q || (state_d == ST_FAULT);
    end

    assign pll_rtc_rst   = pll_rtc_rst_q;
    assign pll_sys_rst   = pll_sys_rst_q;
    assign periph_rst_n  = periph_rst_n_q;
    assign core_rst_n    = core_rst_n_q;
    assign running       = running_q;
    assign fault         = fault_q;
    assign seq_state     = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters.
module tb_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock_rtc = 1'b0;
    logic       pll_lock_sys = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rtc_rst, pll_sys_rst, periph_rst_n, core_rst_n, running, fault;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pll_rst_seq #(
        .RST_CYC(4), .STABLE_CYC(8), .TMO_CYC(64), .GAP_CYC(4), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pll_lock_rtc(pll_lock_rtc), .pll_lock_sys(pll_lock_sys),
        .restart_req(restart_req),
        .pll_rtc_rst(pll_rtc_rst), .pll_sys_rst(pll_sys_rst),
        .periph_rst_n(periph_rst_n), .core_rst_n(core_rst_n),
        .running(running), .fault(fault),
        .seq_state(seq_state), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_reset(input logic rtc, input logic sys);
        @(negedge clk);
        rst_n        = 1'b0;
        pll_lock_rtc = rtc;
        pll_lock_sys = sys;
        restart_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Checks a full bring-up with both locks high; edge 1 is the first edge in RST_PLL.
    task automatic run_seq(input string tag, input int restart_at, input int stop_at);
        logic [2:0] e_state;
        logic       e_rtc, e_sys, e_per, e_core;
        for (int k = 1; k <= stop_at; k++) begin
            @(posedge clk); #1;
            e_state = (k < 4) ? 3'd0 : (k < 14) ? 3'd1 : (k < 24) ? 3'd2 : (k < 28) ? 3'd3 : 3'd4;
            e_rtc   = (k < 4);
            e_sys   = (k < 14);
            e_per   = (k >= 24);
            e_core  = (k >= 28);
            n_checks++;
            if (seq_state !== e_state) begin
                n_fail++;
                $display("FAIL %s seq_state edge %0d: got %0d expected %0d", tag, k, seq_state, e_state);
            end
            n_checks++;
            if (pll_rtc_rst !== e_rtc) begin
                n_fail++;
                $display("FAIL %s pll_rtc_rst edge %0d: got %b expected %b", tag, k, pll_rtc_rst, e_rtc);
            end
            n_checks++;
            if (pll_sys_rst !== e_sys) begin
                n_fail++;
                $display("FAIL %s pll_sys_rst edge %0d: got %b expected %b", tag, k, pll_sys_rst, e_sys);
            end
            n_checks++;
            if (periph_rst_n !== e_per) begin
                n_fail++;
                $display("FAIL %s periph_rst_n edge %0d: got %b expected %b", tag, k, periph_rst_n, e_per);
            end
            n_checks++;
            if (core_rst_n !== e_core) begin
                n_fail++;
                $display("FAIL %s core_rst_n edge %0d: got %b expected %b", tag, k, core_rst_n, e_core);
            end
            n_checks++;
            if (running !== e_core) begin
                n_fail++;
                $display("FAIL %s running edge %0d: got %b expected %b", tag, k, running, e_core);
            end
            restart_req = (k == restart_at);
        end
        restart_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({seq_state, pll_rtc_rst, pll_sys_rst, periph_rst_n, core_rst_n, running, fault, lock_loss_cnt}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got st=%0d rtc=%b sys=%b per=%b core=%b run=%b flt=%b loss=%0d expected st=0 rtc=1 sys=1 per=0 core=0 run=0 flt=0 loss=0",
                     seq_state, pll_rtc_rst, pll_sys_rst, periph_rst_n, core_rst_n, running, fault, lock_loss_cnt);
        end
    endtask

    task automatic test_nominal();
        apply_reset(1'b1, 1'b1);
        run_seq("nominal", 0, 30);
    endtask

    task automatic test_lock_loss();
        pll_lock_sys = 1'b0;
        @(posedge clk); #1;
        pll_lock_sys = 1'b1;
        n_checks++;
        if (core_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_loss core_rst_n +1: got %b expected 1", core_rst_n);
        end
        @(posedge clk); #1;
        n_checks++;
        if (core_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_loss core_rst_n +2: got %b expected 1", core_rst_n);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({core_rst_n, periph_rst_n, pll_rtc_rst, pll_sys_rst, seq_state} !== {1'b0, 1'b0, 1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL lock_loss outputs +3: got core=%b per=%b rtc=%b sys=%b st=%0d expected core=0 per=0 rtc=1 sys=1 st=0",
                     core_rst_n, periph_rst_n, pll_rtc_rst, pll_sys_rst, seq_state);
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL lock_loss_cnt: got %0d expected 1", lock_loss_cnt);
        end
        run_seq("lock_loss_rerun", 0, 30);
    endtask

    task automatic test_restart();
        restart_req = 1'b1;
        @(posedge clk); #1;
        restart_req = 1'b0;
        n_checks++;
        if ({seq_state, core_rst_n, periph_rst_n} !== {3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL restart entry: got st=%0d core=%b per=%b expected st=0 core=0 per=0", seq_state, core_rst_n, periph_rst_n);
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL restart lock_loss_cnt: got %0d expected 1", lock_loss_cnt);
        end
        // Pulse lands in WAIT_RTC and must not disturb the sequence.
        run_seq("restart_rerun", 6, 30);
        n_checks++;
        if (lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL restart lock_loss_cnt after rerun: got %0d expected 1", lock_loss_cnt);
        end
    endtask

    task automatic test_mid_reset();
        restart_req = 1'b1;
        @(posedge clk); #1;
        restart_req = 1'b0;
        run_seq("mid_reset", 0, 25);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({seq_state, pll_rtc_rst, pll_sys_rst, periph_rst_n, core_rst_n, running, fault, lock_loss_cnt}
            !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_reset async: got st=%0d rtc=%b sys=%b per=%b core=%b run=%b flt=%b loss=%0d expected st=0 rtc=1 sys=1 per=0 core=0 run=0 flt=0 loss=0",
                     seq_state, pll_rtc_rst, pll_sys_rst, periph_rst_n, core_rst_n, running, fault, lock_loss_cnt);
        end
    endtask

    task automatic test_glitchy_lock();
        apply_reset(1'b0, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (k == 6 || k == 12) pll_lock_rtc = 1'b1;
            if (k == 11)           pll_lock_rtc = 1'b0;
            if (k == 21) begin
                n_checks++;
                if ({seq_state, pll_sys_rst} !== {3'd1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL glitch edge 21: got st=%0d sys_rst=%b expected st=1 sys_rst=1", seq_state, pll_sys_rst);
                end
            end
            if (k == 22) begin
                n_checks++;
                if ({seq_state, pll_sys_rst} !== {3'd2, 1'b0}) begin
                    n_fail++;
                    $display("FAIL glitch edge 22: got st=%0d sys_rst=%b expected st=2 sys_rst=0", seq_state, pll_sys_rst);
                end
            end
            if (k == 31) begin
                n_checks++;
                if (periph_rst_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch periph edge 31: got %b expected 0", periph_rst_n);
                end
            end
            if (k == 32) begin
                n_checks++;
                if ({seq_state, periph_rst_n} !== {3'd3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL glitch edge 32: got st=%0d per=%b expected st=3 per=1", seq_state, periph_rst_n);
                end
            end
        end
    endtask

    task automatic test_timeout_fault();
        logic [2:0] e_state;
        apply_reset(1'b1, 1'b0);
        for (int k = 1; k <= 240; k++) begin
            @(posedge clk); #1;
            e_state = 3'd7;
            case (k)
                14, 77, 92, 155, 170, 233: e_state = 3'd2;
                78, 156:                   e_state = 3'd0;
                234, 240:                  e_state = 3'd5;
                default:                   e_state = 3'd7;
            endcase
            if (e_state != 3'd7) begin
                n_checks++;
                if (seq_state !== e_state) begin
                    n_fail++;
                    $display("FAIL timeout seq_state edge %0d: got %0d expected %0d", k, seq_state, e_state);
                end
            end
            if (k == 233) begin
                n_checks++;
                if (fault !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout fault early edge 233: got %b expected 0", fault);
                end
            end
            if (k == 234) begin
                n_checks++;
                if ({fault, core_rst_n, periph_rst_n, pll_rtc_rst, pll_sys_rst, running} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fault outputs: got flt=%b core=%b per=%b rtc=%b sys=%b run=%b expected flt=1 core=0 per=0 rtc=1 sys=1 run=0",
                             fault, core_rst_n, periph_rst_n, pll_rtc_rst, pll_sys_rst, running);
                end
            end
        end
        pll_lock_sys = 1'b1;
        restart_req  = 1'b1;
        @(posedge clk); #1;
        restart_req  = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if ({seq_state, fault} !== {3'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL fault sticky: got st=%0d flt=%b expected st=5 flt=1", seq_state, fault);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({seq_state, fault, pll_rtc_rst} !== {3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fault cleared by rst_n: got st=%0d flt=%b rtc=%b expected st=0 flt=0 rtc=1", seq_state, fault, pll_rtc_rst);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_restart();
        test_mid_reset();
        test_glitchy_lock();
        test_timeout_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
